// File: rtl/whack_pkg.sv
// Shared definitions for the Whack-A-Mole game-phase controller.
package whack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAP  = 3'd1,
        ST_UP   = 3'd2,
        ST_HIT  = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3 into bit 0
    localparam logic [7:0] LFSR_SEED   = 8'hA5;
    localparam logic [7:0] LFSR_TAPS   = 8'b1011_1000;
    localparam logic [7:0] SCORE_MAX   = 8'd99;
    // last ms index inside one second of the round timer
    localparam logic [9:0] SEC_LAST_MS = 10'd999;

    // One-hot difficulty -> mole up-time in ms; zero or multi-hot selects level 1
    function automatic logic [10:0] level_up_ms(input logic [7:0]  diff,
                                                input logic [10:0] base_ms,
                                                input logic [10:0] step_ms);
        logic [3:0] level;
        logic [3:0] ones;
        level = 4'd1;
        ones  = 4'd0;
        for (int k = 0; k < 8; k++) begin
            if (diff[k]) begin
                ones  = ones + 4'd1;
                level = 4'(k) + 4'd1;
            end else begin
                ones  = ones;
            end
        end
        if (ones != 4'd1) begin
            level = 4'd1;
        end else begin
            level = level;
        end
        return base_ms - (11'(level - 4'd1) * step_ms);
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Fibonacci LFSR; step_pos previews the low 3 bits of the next value.
module mole_lfsr
    import whack_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    output logic [2:0] step_pos
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic [7:0] lfsr_nxt_s;

    // Next LFSR value and the hold/step choice
    always_comb begin
        lfsr_nxt_s = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        step_pos   = lfsr_nxt_s[2:0];
        if (step) begin
            lfsr_d = lfsr_nxt_s;
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR register, seeded on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Game-phase controller: runs one timed round of mole pop-ups and scores hits.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int TICK_CYCLES = 100000,
    parameter int ROUND_S     = 60,
    parameter int BASE_UP_MS  = 1600,
    parameter int STEP_MS     = 180,
    parameter int GAP_MS      = 300,
    parameter int HIT_MS      = 200,
    parameter int MISS_LIMIT  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_game,
    input  logic [7:0] difficulty,
    input  logic [7:0] hit_btn,
    output logic [7:0] mole_led,
    output logic [7:0] score,
    output logic [3:0] miss_cnt,
    output logic [6:0] time_left,
    output logic       busy,
    output logic       game_over
);

    localparam int            PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    state_t        st_q, st_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [10:0]   ms_q, ms_d, ms_inc_s, up_ms_q, up_ms_d;
    logic [9:0]    sec_ms_q, sec_ms_d;
    logic [6:0]    time_left_q, time_left_d;
    logic [7:0]    score_q, score_d;
    logic [3:0]    miss_q, miss_d;
    logic [2:0]    pos_q, pos_d, step_pos_s, new_pos_s;
    logic [7:0]    btn_q, rise_s;
    logic [7:0]    mole_led_q, mole_led_d;
    logic          busy_q, busy_d, game_over_q, game_over_d;
    logic          tick_s, lfsr_step_s;

    mole_lfsr u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (lfsr_step_s),
        .step_pos (step_pos_s)
    );

    // Next-state, timers, counters and the registered output image
    always_comb begin
        tick_s      = (presc_q == PRESC_LAST);
        rise_s      = hit_btn & ~btn_q;
        ms_inc_s    = ms_q + 11'd1;
        new_pos_s   = (step_pos_s == pos_q) ? (step_pos_s + 3'd1) : step_pos_s;
        lfsr_step_s = 1'b0;
        st_d        = st_q;
        presc_d     = tick_s ? '0 : (presc_q + PW'(1));
        ms_d        = ms_q;
        sec_ms_d    = sec_ms_q;
        time_left_d = time_left_q;
        score_d     = score_q;
        miss_d      = miss_q;
        up_ms_d     = up_ms_q;
        pos_d       = pos_q;

        case (st_q)
            ST_IDLE: begin
                if (start_game) begin
                    st_d        = ST_GAP;
                    presc_d     = '0;
                    ms_d        = 11'd0;
                    sec_ms_d    = 10'd0;
                    time_left_d = 7'(ROUND_S);
                    score_d     = 8'd0;
                    miss_d      = 4'd0;
                    up_ms_d     = level_up_ms(difficulty, 11'(BASE_UP_MS), 11'(STEP_MS));
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_GAP, ST_UP, ST_HIT: begin
                if (!start_game) begin
                    st_d = ST_IDLE;
                end else if (time_left_q == 7'd0) begin
                    st_d = ST_OVER;
                end else begin
                    // round clock only runs while a mole cycle is in play
                    if (tick_s) begin
                        ms_d = ms_inc_s;
                        if (sec_ms_q == SEC_LAST_MS) begin
                            sec_ms_d    = 10'd0;
                            time_left_d = time_left_q - 7'd1;
                        end else begin
                            sec_ms_d = sec_ms_q + 10'd1;
                        end
                    end else begin
                        ms_d = ms_q;
                    end
                    case (st_q)
                        ST_GAP: begin
                            if (tick_s && (ms_inc_s == 11'(GAP_MS))) begin
                                lfsr_step_s = 1'b1;
                                pos_d       = new_pos_s;
                                st_d        = ST_UP;
                                ms_d        = 11'd0;
                            end else begin
                                st_d = ST_GAP;
                            end
                        end
                        ST_UP: begin
                            // a hit edge beats a same-cycle timeout
                            if (rise_s[pos_q]) begin
                                score_d = (score_q >= SCORE_MAX) ? SCORE_MAX : (score_q + 8'd1);
                                st_d    = ST_HIT;
                                ms_d    = 11'd0;
                            end else if (tick_s && (ms_inc_s == up_ms_q)) begin
                                miss_d = miss_q + 4'd1;
                                st_d   = ((miss_q + 4'd1) == 4'(MISS_LIMIT)) ? ST_OVER : ST_GAP;
                                ms_d   = 11'd0;
                            end else begin
                                st_d = ST_UP;
                            end
                        end
                        default: begin
                            if (tick_s && (ms_inc_s == 11'(HIT_MS))) begin
                                st_d = ST_GAP;
                                ms_d = 11'd0;
                            end else begin
                                st_d = ST_HIT;
                            end
                        end
                    endcase
                end
            end
            ST_OVER: begin
                if (!start_game) begin
                    st_d = ST_IDLE;
                end else begin
                    st_d = ST_OVER;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase

        case (st_d)
            ST_GAP:  begin mole_led_d = 8'h00;         busy_d = 1'b1; game_over_d = 1'b0; end
            ST_UP:   begin mole_led_d = 8'd1 << pos_d; busy_d = 1'b1; game_over_d = 1'b0; end
            ST_HIT:  begin mole_led_d = 8'hFF;         busy_d = 1'b1; game_over_d = 1'b0; end
            ST_OVER: begin mole_led_d = 8'hFF;         busy_d = 1'b0; game_over_d = 1'b1; end
            default: begin mole_led_d = 8'h00;         busy_d = 1'b0; game_over_d = 1'b0; end
        endcase
    end

    // State, timer, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= ST_IDLE;
            presc_q     <= '0;
            ms_q        <= 11'd0;
            sec_ms_q    <= 10'd0;
            time_left_q <= 7'(ROUND_S);
            score_q     <= 8'd0;
            miss_q      <= 4'd0;
            up_ms_q     <= 11'(BASE_UP_MS);
            pos_q       <= 3'd0;
            btn_q       <= 8'h00;
            mole_led_q  <= 8'h00;
            busy_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            st_q        <= st_d;
            presc_q     <= presc_d;
            ms_q        <= ms_d;
            sec_ms_q    <= sec_ms_d;
            time_left_q <= time_left_d;
            score_q     <= score_d;
            miss_q      <= miss_d;
            up_ms_q     <= up_ms_d;
            pos_q       <= pos_d;
            btn_q       <= hit_btn;
            mole_led_q  <= mole_led_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign mole_led  = mole_led_q;
    assign score     = score_q;
    assign miss_cnt  = miss_q;
    assign time_left = time_left_q;
    assign busy      = busy_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: a behavioural game model predicts every
// change of the output tuple with its cycle stamp; a monitor compares each
// change the DUT shows against the next prediction.
module tb_mole_scheduler;

    localparam int TCK = 4, RS = 3, GAPT = 3, HITT = 2, BASE = 1600, STEP = 180, MLIM = 5;
    localparam int PH_IDLE = 0, PH_GAP = 1, PH_UP = 2, PH_HIT = 3, PH_OVER = 4;
    localparam logic [28:0] RESET_TUPLE = {8'h00, 8'h00, 4'h0, 7'd3, 1'b0, 1'b0};

    typedef struct {
        int          cyc;
        logic [28:0] val;
    } exp_t;

    logic       clk, rst_n, start_game, busy, game_over;
    logic [7:0] difficulty, hit_btn, mole_led, score;
    logic [3:0] miss_cnt;
    logic [6:0] time_left;

    exp_t exp_q[$];
    int   cyc_n = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   stim_timeouts = 0;
    bit   done = 1'b0;

    // behavioural game model
    int          m_ph, m_presc, m_ph_ms, m_elapsed, m_up, m_score, m_miss;
    logic [7:0]  m_lfsr, m_prev_btn;
    logic [2:0]  m_pos;
    logic [28:0] m_last;

    mole_scheduler #(
        .TICK_CYCLES (TCK),
        .ROUND_S     (RS),
        .BASE_UP_MS  (BASE),
        .STEP_MS     (STEP),
        .GAP_MS      (GAPT),
        .HIT_MS      (HITT),
        .MISS_LIMIT  (MLIM)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_game (start_game),
        .difficulty (difficulty),
        .hit_btn    (hit_btn),
        .mole_led   (mole_led),
        .score      (score),
        .miss_cnt   (miss_cnt),
        .time_left  (time_left),
        .busy       (busy),
        .game_over  (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_up(logic [7:0] d);
        int lvl;
        lvl = 1;
        if ($countones(d) == 1) begin
            for (int k = 0; k < 8; k++) if (d[k]) lvl = k + 1;
        end
        return BASE - (lvl - 1) * STEP;
    endfunction

    function automatic logic [28:0] model_tuple();
        logic [7:0] led;
        logic       b, g;
        led = 8'h00; b = 1'b0; g = 1'b0;
        if (m_ph == PH_GAP) b = 1'b1;
        if (m_ph == PH_UP)  begin led = 8'd1 << m_pos; b = 1'b1; end
        if (m_ph == PH_HIT) begin led = 8'hFF; b = 1'b1; end
        if (m_ph == PH_OVER) begin led = 8'hFF; g = 1'b1; end
        return {led, 8'(m_score), 4'(m_miss), 7'(RS - m_elapsed / 1000), b, g};
    endfunction

    task automatic model_reset();
        m_ph = PH_IDLE; m_presc = 0; m_ph_ms = 0; m_elapsed = 0; m_up = BASE;
        m_score = 0; m_miss = 0; m_lfsr = 8'hA5; m_prev_btn = 8'h00; m_pos = 3'd0;
    endtask

    // one clock edge of the game rules, using the inputs currently applied
    task automatic model_edge();
        logic [7:0] rise;
        logic [2:0] np;
        bit         tick;
        int         tl;
        tick = (m_presc == TCK - 1);
        rise = hit_btn & ~m_prev_btn;
        m_prev_btn = hit_btn;
        m_presc = tick ? 0 : m_presc + 1;
        tl = RS - m_elapsed / 1000;
        if (m_ph == PH_IDLE) begin
            if (start_game) begin
                m_ph = PH_GAP; m_score = 0; m_miss = 0; m_elapsed = 0; m_ph_ms = 0;
                m_presc = 0; m_up = ref_up(difficulty);
            end
        end else if (m_ph == PH_OVER) begin
            if (!start_game) m_ph = PH_IDLE;
        end else if (!start_game) begin
            m_ph = PH_IDLE;
        end else if (tl == 0) begin
            m_ph = PH_OVER;
        end else begin
            if (tick) begin m_elapsed++; m_ph_ms++; end
            if (m_ph == PH_GAP) begin
                if (tick && m_ph_ms == GAPT) begin
                    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
                    np = m_lfsr[2:0];
                    if (np == m_pos) np = np + 3'd1;
                    m_pos = np; m_ph = PH_UP; m_ph_ms = 0;
                end
            end else if (m_ph == PH_UP) begin
                if (rise[m_pos]) begin
                    m_score = (m_score >= 99) ? 99 : m_score + 1;
                    m_ph = PH_HIT; m_ph_ms = 0;
                end else if (tick && m_ph_ms == m_up) begin
                    m_miss++;
                    m_ph = (m_miss == MLIM) ? PH_OVER : PH_GAP;
                    m_ph_ms = 0;
                end
            end else begin
                if (tick && m_ph_ms == HITT) begin m_ph = PH_GAP; m_ph_ms = 0; end
            end
        end
    endtask

    task automatic push_if_changed();
        logic [28:0] t;
        t = model_tuple();
        if (t != m_last) begin
            exp_q.push_back('{cyc_n, t});
            m_last = t;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        cyc_n++;
        push_if_changed();
        @(negedge clk);
        #1;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_ph(int ph, int budget);
        int b;
        b = budget;
        while (m_ph != ph && b > 0) begin cyc(); b--; end
        if (m_ph != ph) stim_timeouts++;
    endtask

    // reset pulse lying wholly between two rising edges
    task automatic reset_pulse();
        model_edge();
        @(posedge clk);
        cyc_n++;
        #1 rst_n = 1'b0;
        model_reset();
        push_if_changed();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // stimulus
    initial begin
        int b, r;
        rst_n = 1'b0; start_game = 1'b0; difficulty = 8'h00; hit_btn = 8'h00;
        model_reset();
        m_last = RESET_TUPLE;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // idle with button noise: nothing may move
        for (int i = 0; i < 1000; i++) begin
            if (i % 37 == 0) hit_btn = 8'($urandom);
            cyc();
        end
        hit_btn = 8'h00;

        // level 1, no presses: 1600-tick miss, then the round clock expires
        difficulty = 8'h01; start_game = 1'b1;
        wait_ph(PH_OVER, 13000);
        run(10);
        start_game = 1'b0;
        run(10);

        // level 8: hit, held button, wrong button, hit/timeout collision, miss-out
        difficulty = 8'h80; start_game = 1'b1;
        wait_ph(PH_UP, 100);
        run(400);
        hit_btn = 8'd1 << m_pos; cyc(); hit_btn = 8'h00;
        wait_ph(PH_GAP, 100);
        hit_btn = 8'hFF;
        wait_ph(PH_UP, 100);
        wait_ph(PH_GAP, 2000);
        hit_btn = 8'h00;
        wait_ph(PH_UP, 100);
        run(40);
        hit_btn = ~(8'd1 << m_pos); cyc(); hit_btn = 8'h00;
        wait_ph(PH_GAP, 2000);
        wait_ph(PH_UP, 100);
        b = 3000;
        while (!(m_presc == TCK - 1 && m_ph_ms == m_up - 1) && b > 0) begin cyc(); b--; end
        if (b == 0) stim_timeouts++;
        hit_btn = 8'd1 << m_pos; cyc(); hit_btn = 8'h00;
        wait_ph(PH_OVER, 6000);
        run(20);
        reset_pulse();
        start_game = 1'b0;
        run(10);

        // randomized round with random difficulty and button activity
        r = $urandom_range(0, 2);
        difficulty = (r == 0) ? (8'd1 << $urandom_range(0, 7)) : ((r == 1) ? 8'h00 : 8'($urandom));
        start_game = 1'b1;
        b = 13000;
        while (m_ph != PH_OVER && b > 0) begin
            if ($urandom_range(0, 39) == 0) begin
                r = $urandom_range(0, 3);
                case (r)
                    0: hit_btn = 8'h00;
                    1: hit_btn = 8'd1 << m_pos;
                    2: hit_btn = 8'($urandom);
                    default: hit_btn = 8'd1 << $urandom_range(0, 7);
                endcase
            end
            cyc();
            b--;
        end
        if (m_ph != PH_OVER) stim_timeouts++;
        hit_btn = 8'h00; start_game = 1'b0;
        run(10);

        // rapid hitting at level 8 drives the score into saturation
        difficulty = 8'h80; start_game = 1'b1;
        b = 13000;
        while (m_ph != PH_OVER && b > 0) begin
            hit_btn = (m_ph == PH_UP && hit_btn == 8'h00) ? (8'd1 << m_pos) : 8'h00;
            cyc();
            b--;
        end
        if (m_ph != PH_OVER) stim_timeouts++;
        hit_btn = 8'h00; start_game = 1'b0;
        run(10);

        // abort mid-UP
        difficulty = 8'h04; start_game = 1'b1;
        wait_ph(PH_UP, 100);
        run(30);
        start_game = 1'b0;
        run(10);
        done = 1'b1;
    end

    // monitor: every change of the DUT outputs is matched against the model
    initial begin
        logic [28:0] prev, cur;
        exp_t        e;
        prev = RESET_TUPLE;
        while (!done) begin
            @(negedge clk);
            cur = {mole_led, score, miss_cnt, time_left, busy, game_over};
            if (cur !== prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change cyc=%0d: led=%h score=%0d miss=%0d tl=%0d busy=%b over=%b, required no change",
                             cyc_n, cur[28:21], cur[20:13], cur[12:9], cur[8:2], cur[1], cur[0]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.val !== cur || e.cyc != cyc_n) begin
                        $display("FAIL out_change: got led=%h score=%0d miss=%0d tl=%0d busy=%b over=%b at cyc %0d, required led=%h score=%0d miss=%0d tl=%0d busy=%b over=%b at cyc %0d",
                                 cur[28:21], cur[20:13], cur[12:9], cur[8:2], cur[1], cur[0], cyc_n,
                                 e.val[28:21], e.val[20:13], e.val[12:9], e.val[8:2], e.val[1], e.val[0], e.cyc);
                    end else begin
                        n_pass++;
                    end
                end
                prev = cur;
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL pending_changes: %0d predicted changes never shown, required 0", exp_q.size());
        end else begin
            n_pass++;
        end
        n_checks++;
        if (stim_timeouts != 0) begin
            $display("FAIL wait_budget: %0d waits expired, required 0", stim_timeouts);
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
